reg_scoreboard: RTL and testbench

//  Parametrised register-hazard scoreboard for the ARM pipeline, replacing the fixed two-stage hazard check.

---
 rtl/arm_pkg.sv | 20 ++
 rtl/sb_pending_counter.sv | 40 ++++
 rtl/reg_scoreboard.sv | 138 +++++++++++++
 tb/tb_reg_scoreboard.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arm_pkg : shared scoreboard types, select constants and default sizes
// Rev 1.0
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int SB_NUM_REGS = 16;
  localparam int SB_REG_W    = $clog2(SB_NUM_REGS);
  localparam int SB_DEPTH    = 3;
  localparam int FWD_RF      = 0;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] dest;
    logic                load;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_pending_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sb_pending_counter : in-flight write count for one architectural register
// Rev 1.0
// ---------------------------------------------------------------------------
module sb_pending_counter #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_retire,
  input  logic [CNT_W-1:0] dec_kill,
  output logic [CNT_W-1:0] count
);

  // One spare bit so the bound checks see the true value instead of a wrap.
  logic [CNT_W:0] up;
  logic [CNT_W:0] down;

  assign up   = {1'b0, count} + {{CNT_W{1'b0}}, inc};
  assign down = {1'b0, dec_kill} + {{CNT_W{1'b0}}, dec_retire};

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= CNT_W'(up - down);
    end
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) up >= down);
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst)
                                   (up - down) <= (CNT_W+1)'(DEPTH));
`endif

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_scoreboard : register-hazard scoreboard, IF/ID stall and forward selects
// Optional feature macro: FORWARDING_EN (stall only on load-use, drive selects)
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_scoreboard
  import arm_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int REG_W    = SB_REG_W,
  parameter int DEPTH    = SB_DEPTH,
  parameter int CNT_W    = $clog2(DEPTH + 1),
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_wb_en,
  input  logic             issue_load,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             src1_valid,
  input  logic [REG_W-1:0] src1,
  input  logic             src2_valid,
  input  logic [REG_W-1:0] src2,
  input  logic [DEPTH-1:0] flush_mask,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             busy
);

  sb_entry_t                      stage [DEPTH];
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            inc;
  logic [NUM_REGS-1:0]            dec_retire;
  logic [NUM_REGS-1:0][CNT_W-1:0] dec_kill;
  logic                           accept;

  assign accept = issue_valid & issue_wb_en & ~stall & ~flush_mask[0];
  assign busy   = |cnt;

`ifdef FORWARDING_EN
  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;
  logic             load1;
  logic             load2;

  // Scan oldest to youngest so the youngest producer overwrites the result.
  always_comb begin
    sel1  = SEL_W'(FWD_RF);
    sel2  = SEL_W'(FWD_RF);
    load1 = 1'b0;
    load2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src1_valid && stage[k].valid && stage[k].dest == src1) begin
        sel1  = SEL_W'(k + 1);
        load1 = stage[k].load;
      end
      if (src2_valid && stage[k].valid && stage[k].dest == src2) begin
        sel2  = SEL_W'(k + 1);
        load2 = stage[k].load;
      end
    end
  end

  assign stall    = (sel1 == SEL_W'(1) && load1) || (sel2 == SEL_W'(1) && load2);
  assign fwd_sel1 = sel1;
  assign fwd_sel2 = sel2;
`else
  assign stall    = (src1_valid && cnt[src1] != '0) || (src2_valid && cnt[src2] != '0);
  assign fwd_sel1 = SEL_W'(FWD_RF);
  assign fwd_sel2 = SEL_W'(FWD_RF);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= accept ? sb_entry_t'{valid: 1'b1, dest: issue_dest, load: issue_load} : '0;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= flush_mask[k-1] ? '0 : stage[k-1];
      end
    end
  end

  // A killed entry in the last stage counts as a kill, never also as a retire.
  always_comb begin
    inc        = '0;
    dec_retire = '0;
    dec_kill   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r]        = accept && issue_dest == REG_W'(r);
      dec_retire[r] = stage[DEPTH-1].valid && !flush_mask[DEPTH-1]
                      && stage[DEPTH-1].dest == REG_W'(r);
      for (int k = 0; k < DEPTH; k++) begin
        if (flush_mask[k] && stage[k].valid && stage[k].dest == REG_W'(r)) begin
          dec_kill[r] = dec_kill[r] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    sb_pending_counter #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc[r]),
      .dec_retire (dec_retire[r]),
      .dec_kill   (dec_kill[r]),
      .count      (cnt[r])
    );
  end

`ifndef SYNTHESIS
  logic [NUM_REGS-1:0][CNT_W-1:0] occ;

  always_comb begin
    occ = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stage[k].valid && stage[k].dest == REG_W'(r)) begin
          occ[r] = occ[r] + CNT_W'(1);
        end
      end
    end
  end

  a_cnt_matches_pipe: assert property (@(posedge clk) disable iff (!rst) occ == cnt);
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_scoreboard : directed vector table, hazard sequences, random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;
  import arm_pkg::*;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wb_en, issue_load;
  logic [3:0] issue_dest;
  logic       src1_valid, src2_valid;
  logic [3:0] src1, src2;
  logic [2:0] flush_mask;
  logic       stall, busy;
  logic [1:0] fwd_sel1, fwd_sel2;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_wb_en (issue_wb_en),
    .issue_load  (issue_load),
    .issue_dest  (issue_dest),
    .src1_valid  (src1_valid),
    .src1        (src1),
    .src2_valid  (src2_valid),
    .src2        (src2),
    .flush_mask  (flush_mask),
    .stall       (stall),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int r);
    return int'(dut.cnt[r]);
  endfunction

  typedef struct {
    int iv, ld, dst, s1v, s1, s2v, s2, fl;
    int st_nf, st_fw, f1, f2, bsy, creg, ecnt;
  } vec_t;

  function automatic vec_t v(input int iv, ld, dst, s1v, s1, s2v, s2, fl,
                             input int st_nf, st_fw, f1, f2, bsy, creg, ecnt);
    vec_t x;
    x.iv = iv; x.ld = ld; x.dst = dst; x.s1v = s1v; x.s1 = s1; x.s2v = s2v; x.s2 = s2;
    x.fl = fl; x.st_nf = st_nf; x.st_fw = st_fw; x.f1 = f1; x.f2 = f2; x.bsy = bsy;
    x.creg = creg; x.ecnt = ecnt;
    return x;
  endfunction

  task automatic drive(input int iv, ld, dst, s1v, s1_, s2v, s2_, fl);
    issue_valid = 1'(iv);
    issue_wb_en = 1'(iv);
    issue_load  = 1'(ld);
    issue_dest  = 4'(dst);
    src1_valid  = 1'(s1v);
    src1        = 4'(s1_);
    src2_valid  = 1'(s2v);
    src2        = 4'(s2_);
    flush_mask  = 3'(fl);
  endtask

  // Producer issues, consumer waits in ID until released; counts stalled cycles.
  task automatic dep_seq(input int pd, input int pl, input int cd, input int use2,
                         input int exp_stalls, input int exp_sel);
    int n;
    bit released;
    @(negedge clk);
    drive(1, pl, pd, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, cd, use2 == 0, pd, use2 != 0, pd, 0);
    n = 0;
    released = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!stall) begin
        released = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
    if (!released) $display("FAIL dep_timeout: consumer of r%0d never released", pd);
    check($sformatf("dep_r%0d_stalls", pd), n, exp_stalls);
    check($sformatf("dep_r%0d_fwd", pd), use2 != 0 ? int'(fwd_sel2) : int'(fwd_sel1), exp_sel);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check($sformatf("dep_r%0d_cnt", cd), cnt_of(cd), 1);
    repeat (4) @(negedge clk);
  endtask

  vec_t tbl [29];
  int mv [3];
  int md [3];
  int ml [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = v(1,0,3, 0,0,0,0, 0,  0,0,0,0,0, 3,0);
    tbl[1]  = v(0,0,0, 1,3,0,0, 0,  1,0,1,0,1, 3,1);
    tbl[2]  = v(0,0,0, 1,3,0,0, 0,  1,0,2,0,1, 3,1);
    tbl[3]  = v(0,0,0, 1,3,0,0, 0,  1,0,3,0,1, 3,1);
    tbl[4]  = v(0,0,0, 1,3,0,0, 0,  0,0,0,0,0, 3,0);
    tbl[5]  = v(1,1,2, 0,0,0,0, 0,  0,0,0,0,0, 2,0);
    tbl[6]  = v(0,0,0, 0,0,1,2, 0,  1,1,0,1,1, 2,1);
    tbl[7]  = v(0,0,0, 0,0,1,2, 0,  1,0,0,2,1, 2,1);
    tbl[8]  = v(1,0,5, 0,0,0,2, 0,  0,0,0,0,1, 2,1);
    tbl[9]  = v(1,0,5, 0,0,0,0, 0,  0,0,0,0,1, 5,1);
    tbl[10] = v(0,0,0, 1,5,0,0, 0,  1,0,1,0,1, 5,2);
    tbl[11] = v(0,0,0, 1,5,1,5, 0,  1,0,2,2,1, 5,2);
    tbl[12] = v(1,0,7, 0,0,0,0, 0,  0,0,0,0,1, 5,1);
    tbl[13] = v(1,0,8, 1,7,0,0, 1,  1,0,1,0,1, 7,1);
    tbl[14] = v(0,0,0, 1,7,0,0, 0,  0,0,0,0,0, 7,0);
    tbl[15] = v(1,0,4, 0,0,0,0, 0,  0,0,0,0,0, 8,0);
    tbl[16] = v(0,0,0, 0,0,0,0, 0,  0,0,0,0,1, 4,1);
    tbl[17] = v(0,0,0, 0,0,0,0, 0,  0,0,0,0,1, 4,1);
    tbl[18] = v(1,0,4, 0,0,0,0, 0,  0,0,0,0,1, 4,1);
    tbl[19] = v(0,0,0, 0,0,1,4, 0,  1,0,0,1,1, 4,1);
    tbl[20] = v(1,0,6, 0,0,0,0, 2,  0,0,0,0,1, 4,1);
    tbl[21] = v(0,0,0, 1,4,1,6, 0,  1,0,0,1,1, 4,0);
    tbl[22] = v(0,0,0, 0,0,0,0, 2,  0,0,0,0,1, 6,1);
    tbl[23] = v(0,0,0, 1,6,0,0, 0,  0,0,0,0,0, 6,0);
    tbl[24] = v(1,0,1, 0,0,0,0, 0,  0,0,0,0,0, 1,0);
    tbl[25] = v(1,0,1, 0,0,0,0, 0,  0,0,0,0,1, 1,1);
    tbl[26] = v(1,0,1, 0,0,0,0, 0,  0,0,0,0,1, 1,2);
    tbl[27] = v(0,0,0, 1,1,0,0, 7,  1,0,1,0,1, 1,3);
    tbl[28] = v(0,0,0, 1,1,0,0, 0,  0,0,0,0,0, 1,0);

    // Reset held with a live issue; nothing may survive it.
    rst = 1'b0;
    drive(1, 0, 9, 1, 9, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 1, 9, 1, 9, 0);
    #2;
    check("rst_stall", int'(stall), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fwd1", int'(fwd_sel1), 0);
    check("rst_cnt9", cnt_of(9), 0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].ld, tbl[i].dst, tbl[i].s1v, tbl[i].s1,
            tbl[i].s2v, tbl[i].s2, tbl[i].fl);
      #2;
      check($sformatf("v%0d_stall", i), int'(stall), FWD ? tbl[i].st_fw : tbl[i].st_nf);
      check($sformatf("v%0d_fwd1", i), int'(fwd_sel1), FWD ? tbl[i].f1 : 0);
      check($sformatf("v%0d_fwd2", i), int'(fwd_sel2), FWD ? tbl[i].f2 : 0);
      check($sformatf("v%0d_busy", i), int'(busy), tbl[i].bsy);
      check($sformatf("v%0d_cnt%0d", i, tbl[i].creg), cnt_of(tbl[i].creg), tbl[i].ecnt);
    end

    dep_seq(10, 0, 11, 0, FWD ? 0 : 3, FWD ? 1 : 0);
    dep_seq(12, 1, 13, 1, FWD ? 1 : 3, FWD ? 2 : 0);

    // Random traffic against a reference pipeline of {valid, dest, load}.
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; md[k] = 0; ml[k] = 0;
    end
    for (int c = 0; c < 300; c++) begin
      int iv, ld, dst, s1v, s1_, s2v, s2_, fl, y1, y2, est, acc, occ, r;
      iv  = int'($urandom_range(0, 1));
      ld  = int'($urandom_range(0, 1));
      dst = int'($urandom_range(0, 3));
      s1v = int'($urandom_range(0, 1));
      s1_ = int'($urandom_range(0, 3));
      s2v = int'($urandom_range(0, 1));
      s2_ = int'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0;
      @(negedge clk);
      drive(iv, ld, dst, s1v, s1_, s2v, s2_, fl);
      y1 = -1;
      y2 = -1;
      for (int k = 2; k >= 0; k--) begin
        if (s1v != 0 && mv[k] != 0 && md[k] == s1_) y1 = k;
        if (s2v != 0 && mv[k] != 0 && md[k] == s2_) y2 = k;
      end
      if (FWD) est = ((y1 == 0 || y2 == 0) && ml[0] != 0) ? 1 : 0;
      else     est = (y1 >= 0 || y2 >= 0) ? 1 : 0;
      r = int'($urandom_range(0, 3));
      occ = 0;
      for (int k = 0; k < 3; k++) if (mv[k] != 0 && md[k] == r) occ++;
      #2;
      check($sformatf("rnd%0d_stall", c), int'(stall), est);
      check($sformatf("rnd%0d_busy", c), int'(busy), (mv[0] | mv[1] | mv[2]) != 0 ? 1 : 0);
      check($sformatf("rnd%0d_fwd1", c), int'(fwd_sel1), FWD ? y1 + 1 : 0);
      check($sformatf("rnd%0d_fwd2", c), int'(fwd_sel2), FWD ? y2 + 1 : 0);
      check($sformatf("rnd%0d_cnt%0d", c, r), cnt_of(r), occ);
      acc = (iv != 0 && est == 0 && (fl & 1) == 0) ? 1 : 0;
      mv[2] = ((fl & 2) != 0) ? 0 : mv[1];
      md[2] = md[1];
      ml[2] = ml[1];
      mv[1] = ((fl & 1) != 0) ? 0 : mv[0];
      md[1] = md[0];
      ml[1] = ml[0];
      mv[0] = acc;
      md[0] = dst;
      ml[0] = ld;
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
